cnt_seq_ctrl: RTL and testbench

//  Run-control sequencer for the team's N-bit synchronous up-counter.

---
 rtl/cnt_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_seq_ctrl
// Run-control sequencer for an N-bit synchronous up-counter. Starts, pauses,
// resumes and aborts counting, detects a programmable terminal value, supports
// one-shot and auto-reload modes and emits a registered one-cycle done pulse.
//
// Optional feature macro: CNT_PRESCALE_EN
//   defined   : a PRE_W-bit prescaler runs in RUN and the count advances only
//               on the cycle the prescaler equals presc (every presc+1 cycles).
//   undefined : the count may advance on every RUN cycle; presc is ignored.
//
// Ports
//   clk          in   1      rising-edge clock
//   rstb         in   1      synchronous active-low reset
//   start        in   1      start from IDLE / resume from HOLD (level)
//   stop         in   1      pause from RUN / abort from HOLD (level)
//   auto_reload  in   1      1: restart at 0 after terminal; 0: one-shot
//   term         in   WIDTH  terminal count value (compared live)
//   presc        in   PRE_W  tick divider (prescaler build only)
//   count        out  WIDTH  current count (registered)
//   busy         out  1      state is RUN or HOLD (registered)
//   done         out  1      one-cycle pulse on terminal count (registered)
//   state_dbg    out  2      current FSM state, for observation
//
// Control handshake: start/stop are plain levels sampled at every rising
// edge; there is no ready/acknowledge. When both are high, stop wins in RUN
// and HOLD, while IDLE only looks at start.
// -----------------------------------------------------------------------------
module cnt_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] term,
  input  logic [PRE_W-1:0] presc,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0] state;
  logic       tick;

  assign state_dbg = state;

`ifdef CNT_PRESCALE_EN
  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == presc);

  // The prescaler only advances on RUN cycles that are not pausing, so a
  // HOLD period resumes exactly where the interval left off.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pre_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      pre_cnt <= '0;
    end else if (state == ST_RUN && !stop) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end
`else
  assign tick = 1'b1;

  logic unused_presc;
  assign unused_presc = ^presc;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Pause wins over a terminal hit: no done on this edge.
            state <= ST_HOLD;
          end else if (tick) begin
            if (count == term) begin
              done <= 1'b1;
              if (auto_reload) begin
                count <= '0;
              end else begin
                // One-shot: count keeps showing the terminal value.
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (start) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_ctrl
// Directed bench for cnt_seq_ctrl. Each driven edge pushes the hand-computed
// {count, busy, done} expected after that edge into exp_q; an independent
// monitor pops and compares shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_cnt_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;
  localparam int W     = WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] term = '0;
  logic [PRE_W-1:0] presc = '0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .term        (term),
    .presc       (presc),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      exp_v = exp_q.pop_front();
      act_v = {count, busy, done};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL out t=%0t count/busy/done got %0d/%0b/%0b want %0d/%0b/%0b",
                 $time, act_v[W-1:2], act_v[1], act_v[0],
                 exp_v[W-1:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Drive inputs for the next rising edge and queue the outputs expected
  // right after that edge.
  task automatic step(input logic r, input logic st, input logic sp,
                      input logic ar, input logic [WIDTH-1:0] tm,
                      input int ec, input logic eb, input logic ed);
    @(negedge clk);
    rstb        = r;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    term        = tm;
    exp_q.push_back({WIDTH'(ec), eb, ed});
  endtask

  initial begin
    presc = '0;

    // Reset state
    step(0, 0, 0, 0, 4'd0, 0, 0, 0);
    step(0, 1, 1, 1, 4'd3, 0, 0, 0);

    // 1: one-shot to term=5
    step(1, 1, 0, 0, 4'd5, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 4'd5, i, 1, 0);
    step(1, 0, 0, 0, 4'd5, 5, 0, 1);
    step(1, 0, 0, 0, 4'd5, 5, 0, 0);
    step(1, 0, 1, 0, 4'd5, 5, 0, 0);   // stop ignored in IDLE

    // 2: auto-reload with term=3
    step(1, 1, 0, 1, 4'd3, 0, 1, 0);
    for (int k = 1; k <= 9; k++) step(1, 0, 0, 1, 4'd3, k % 4, 1, (k % 4) == 0);
    step(1, 0, 1, 1, 4'd3, 1, 1, 0);   // pause
    step(1, 0, 1, 1, 4'd3, 0, 0, 0);   // abort

    // 3: pause / resume / abort with term=9
    step(1, 1, 0, 0, 4'd9, 0, 1, 0);
    step(1, 0, 0, 0, 4'd9, 1, 1, 0);
    step(1, 0, 0, 0, 4'd9, 2, 1, 0);
    step(1, 0, 1, 0, 4'd9, 2, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 4'd9, 2, 1, 0);
    step(1, 1, 0, 0, 4'd9, 2, 1, 0);   // resume edge, count unchanged
    step(1, 0, 0, 0, 4'd9, 3, 1, 0);
    step(1, 0, 1, 0, 4'd9, 3, 1, 0);
    step(1, 0, 1, 0, 4'd9, 0, 0, 0);

    // 4: reset mid-run at count=7 with start high
    step(1, 1, 0, 0, 4'd9, 0, 1, 0);
    for (int i = 1; i <= 7; i++) step(1, 0, 0, 0, 4'd9, i, 1, 0);
    step(0, 1, 0, 0, 4'd9, 0, 0, 0);
    step(1, 0, 0, 0, 4'd9, 0, 0, 0);
    step(1, 0, 0, 0, 4'd9, 0, 0, 0);

    // 5: term=0 with auto-reload, then stop
    step(1, 1, 0, 1, 4'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 4'd0, 0, 1, 1);
    step(1, 0, 1, 1, 4'd0, 0, 1, 0);
    step(1, 0, 1, 1, 4'd0, 0, 0, 0);

    // start and stop together in each state
    step(1, 1, 1, 0, 4'd9, 0, 1, 0);   // IDLE -> RUN
    step(1, 0, 0, 0, 4'd9, 1, 1, 0);
    step(1, 1, 1, 0, 4'd9, 1, 1, 0);   // RUN -> HOLD
    step(1, 1, 1, 0, 4'd9, 0, 0, 0);   // HOLD -> IDLE

    // term lowered below count mid-run: wrap through 15 then stop at 2
    step(1, 1, 0, 0, 4'd9, 0, 1, 0);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 4'd9, i, 1, 0);
    for (int k = 1; k <= 15; k++) step(1, 0, 0, 0, 4'd2, (3 + k) % 16, 1, 0);
    step(1, 0, 0, 0, 4'd2, 2, 0, 1);
    step(1, 0, 0, 0, 4'd2, 2, 0, 0);

`ifdef CNT_PRESCALE_EN
    // 6: prescaler presc=2, term=2, one-shot
    presc = 4'd2;
    step(1, 1, 0, 0, 4'd2, 0, 1, 0);
    for (int e = 1; e <= 8; e++) step(1, 0, 0, 0, 4'd2, e / 3, 1, 0);
    step(1, 0, 0, 0, 4'd2, 2, 0, 1);
    step(1, 0, 0, 0, 4'd2, 2, 0, 0);
`endif

    // drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 50) begin
        @(posedge clk);
        budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending %0d want 0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
